// File: rtl/hbm_pkg.sv
// Shared definitions for the heartbeat monitor: FSM state encoding and the
// helpers that derive the acceptance window from PERIOD and TOL.
package hbm_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SYNC  = 2'd1;
  localparam logic [1:0] ST_TRACK = 2'd2;
  localparam logic [1:0] ST_ALARM = 2'd3;

  function automatic int win_lo(input int period, input int tol);
    return period - tol;
  endfunction

  function automatic int win_hi(input int period, input int tol);
    return period + tol;
  endfunction

  // A late timeout reloads the counter as if a beat had landed on time.
  function automatic int late_reload(input int tol);
    return tol + 1;
  endfunction

endpackage

// File: rtl/heartbeat_monitor_if.sv
// Heartbeat monitor signal bundle: the source side drives enable/beat_in,
// the monitor side returns the status pulses and counters.
interface heartbeat_monitor_if #(
  parameter int CNT_W      = 8,
  parameter int MISS_LIMIT = 3
);
  localparam int MC_W = $clog2(MISS_LIMIT + 1);

  logic             enable;
  logic             beat_in;
  logic             ok;
  logic             early_err;
  logic             late_err;
  logic             alarm;
  logic [MC_W-1:0]  miss_count;
  logic [CNT_W-1:0] interval;

  modport master (
    output enable, beat_in,
    input  ok, early_err, late_err, alarm, miss_count, interval
  );

  modport slave (
    input  enable, beat_in,
    output ok, early_err, late_err, alarm, miss_count, interval
  );

endinterface

// File: rtl/hbm_interval_counter.sv
// Loadable up-counter measuring cycles since the last (real or virtual) beat;
// saturates at all-ones instead of wrapping.
module hbm_interval_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             en,
  output logic [CNT_W-1:0] cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_W'(1);
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (en) begin
      cnt <= sat_inc(cnt);
    end
  end

endmodule

// File: rtl/heartbeat_monitor.sv
// Liveness checker for a periodic 1-cycle beat: classifies each beat against
// the PERIOD+/-TOL window, counts consecutive faults and raises a sticky alarm.
module heartbeat_monitor
  import hbm_pkg::*;
#(
  parameter int PERIOD     = 10,
  parameter int TOL        = 1,
  parameter int MISS_LIMIT = 3,
  parameter int CNT_W      = 8
) (
  input  logic               clk,
  input  logic               reset,
  heartbeat_monitor_if.slave hb
);

  localparam int MC_W = $clog2(MISS_LIMIT + 1);

  localparam logic [CNT_W-1:0] WIN_LO   = CNT_W'(win_lo(PERIOD, TOL));
  localparam logic [CNT_W-1:0] WIN_HI   = CNT_W'(win_hi(PERIOD, TOL));
  localparam logic [CNT_W-1:0] RELOAD   = CNT_W'(late_reload(TOL));
  localparam logic [MC_W-1:0]  MISS_MAX = MC_W'(MISS_LIMIT);

  logic [1:0]       state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] load_val;
  logic             cnt_load;
  logic             cnt_en;
  logic [MC_W-1:0]  miss_q;
  logic [MC_W-1:0]  miss_inc;
  logic [CNT_W-1:0] interval_q;
  logic             ok_q;
  logic             early_q;
  logic             late_q;
  logic             alarm_q;

  function automatic logic [MC_W-1:0] sat_miss(input logic [MC_W-1:0] v);
    return (v == MISS_MAX) ? v : v + MC_W'(1);
  endfunction

  assign miss_inc = sat_miss(miss_q);

  hbm_interval_counter #(
    .CNT_W (CNT_W)
  ) u_cnt (
    .clk      (clk),
    .reset    (reset),
    .load     (cnt_load),
    .load_val (load_val),
    .en       (cnt_en),
    .cnt      (cnt)
  );

  // Counter runs only in TRACK; held at 0 while idle or syncing, frozen in ALARM.
  always_comb begin
    cnt_load = 1'b0;
    load_val = '0;
    cnt_en   = 1'b0;
    if (!hb.enable || state == ST_IDLE) begin
      cnt_load = 1'b1;
    end else if (state == ST_SYNC) begin
      if (hb.beat_in) begin
        cnt_load = 1'b1;
        load_val = CNT_W'(1);
      end
    end else if (state == ST_TRACK) begin
      if (hb.beat_in) begin
        cnt_load = 1'b1;
        load_val = CNT_W'(1);
      end else if (cnt >= WIN_HI) begin
        cnt_load = 1'b1;
        load_val = RELOAD;
      end else begin
        cnt_en = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ST_IDLE;
      ok_q       <= 1'b0;
      early_q    <= 1'b0;
      late_q     <= 1'b0;
      alarm_q    <= 1'b0;
      miss_q     <= '0;
      interval_q <= '0;
    end else begin
      ok_q    <= 1'b0;
      early_q <= 1'b0;
      late_q  <= 1'b0;
      if (!hb.enable) begin
        state   <= ST_IDLE;
        miss_q  <= '0;
        alarm_q <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: state <= ST_SYNC;
          ST_SYNC: if (hb.beat_in) state <= ST_TRACK;
          ST_TRACK: begin
            if (hb.beat_in) begin
              interval_q <= cnt;
              if (cnt < WIN_LO) begin
                early_q <= 1'b1;
                miss_q  <= miss_inc;
                if (miss_inc == MISS_MAX) begin
                  state   <= ST_ALARM;
                  alarm_q <= 1'b1;
                end
              end else begin
                ok_q   <= 1'b1;
                miss_q <= '0;
              end
            end else if (cnt >= WIN_HI) begin
              late_q <= 1'b1;
              miss_q <= miss_inc;
              if (miss_inc == MISS_MAX) begin
                state   <= ST_ALARM;
                alarm_q <= 1'b1;
              end
            end
          end
          default: state <= ST_ALARM;
        endcase
      end
    end
  end

  assign hb.ok         = ok_q;
  assign hb.early_err  = early_q;
  assign hb.late_err   = late_q;
  assign hb.alarm      = alarm_q;
  assign hb.miss_count = miss_q;
  assign hb.interval   = interval_q;

endmodule

// File: tb/tb_heartbeat_monitor.sv
// Scoreboard bench for heartbeat_monitor: a time-stamp based model predicts
// each cycle's outputs as stimulus is driven; the DUT result is checked after the edge.
module tb_heartbeat_monitor;

  localparam int PERIOD     = 10;
  localparam int TOL        = 1;
  localparam int MISS_LIMIT = 3;
  localparam int CNT_W      = 8;

  typedef struct {
    logic ok;
    logic early;
    logic late;
    logic alarm;
    int   miss;
    int   interval;
  } exp_t;

  logic clk = 1'b0;
  logic reset;

  heartbeat_monitor_if #(.CNT_W(CNT_W), .MISS_LIMIT(MISS_LIMIT)) hb();

  heartbeat_monitor #(
    .PERIOD     (PERIOD),
    .TOL        (TOL),
    .MISS_LIMIT (MISS_LIMIT),
    .CNT_W      (CNT_W)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .hb    (hb)
  );

  always #5 clk = ~clk;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  // Model state: 0 idle, 1 sync, 2 track, 3 alarm; m_ref is the cycle of the last real/virtual beat.
  int   m_state = 0;
  int   m_t = 0;
  int   m_ref = 0;
  int   m_miss = 0;
  int   m_interval = 0;
  logic m_alarm = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_step(input logic en, input logic b, output exp_t e);
    int d;
    e.ok = 1'b0; e.early = 1'b0; e.late = 1'b0;
    if (!en) begin
      m_state = 0; m_miss = 0; m_alarm = 1'b0;
    end else begin
      case (m_state)
        0: m_state = 1;
        1: if (b) begin m_ref = m_t; m_state = 2; end
        2: begin
          d = m_t - m_ref;
          if (b) begin
            m_interval = d;
            m_ref = m_t;
            if (d < PERIOD - TOL) begin e.early = 1'b1; m_miss++; end
            else begin e.ok = 1'b1; m_miss = 0; end
          end else if (d == PERIOD + TOL) begin
            e.late = 1'b1;
            m_miss++;
            m_ref = m_t - TOL;
          end
          if (m_miss >= MISS_LIMIT) begin
            m_miss = MISS_LIMIT; m_state = 3; m_alarm = 1'b1;
          end
        end
        default: ;
      endcase
    end
    m_t++;
    e.alarm = m_alarm; e.miss = m_miss; e.interval = m_interval;
  endtask

  task automatic cyc(input logic en, input logic b);
    exp_t e;
    exp_t got;
    @(negedge clk);
    hb.enable  = en;
    hb.beat_in = b;
    model_step(en, b, e);
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    got = sb_q.pop_front();
    check_eq("ok",         hb.ok,         got.ok);
    check_eq("early_err",  hb.early_err,  got.early);
    check_eq("late_err",   hb.late_err,   got.late);
    check_eq("alarm",      hb.alarm,      got.alarm);
    check_eq("miss_count", hb.miss_count, got.miss);
    check_eq("interval",   hb.interval,   got.interval);
  endtask

  task automatic gap(input int n);
    cyc(1'b1, 1'b1);
    repeat (n - 1) cyc(1'b1, 1'b0);
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_ok"},       hb.ok,         0);
    check_eq({tag, "_early"},    hb.early_err,  0);
    check_eq({tag, "_late"},     hb.late_err,   0);
    check_eq({tag, "_alarm"},    hb.alarm,      0);
    check_eq({tag, "_miss"},     hb.miss_count, 0);
    check_eq({tag, "_interval"}, hb.interval,   0);
  endtask

  initial begin
    reset      = 1'b1;
    hb.enable  = 1'b0;
    hb.beat_in = 1'b0;
    #12;
    check_all_zero("reset");
    @(negedge clk);
    reset = 1'b0;

    // Nominal: first beat only synchronises, then ok every 10 cycles.
    cyc(1'b1, 1'b0);
    repeat (4) gap(10);
    check_eq("nom_interval", hb.interval, 10);
    check_eq("nom_miss", hb.miss_count, 0);

    // Window edges: 10, 9, 11 ok; 8 early; 10 ok clears the count.
    gap(9);
    gap(11);
    check_eq("edge_int9", hb.interval, 9);
    gap(8);
    check_eq("edge_int11", hb.interval, 11);
    gap(10);
    check_eq("edge_early_miss", hb.miss_count, 1);
    gap(10);
    check_eq("edge_recover_miss", hb.miss_count, 0);

    // Silence: three late timeouts PERIOD apart lead to the alarm.
    cyc(1'b1, 1'b1);
    repeat (40) cyc(1'b1, 1'b0);
    check_eq("silence_alarm", hb.alarm, 1);
    check_eq("silence_miss", hb.miss_count, 3);

    // Enable drop clears alarm; re-enable resynchronises.
    cyc(1'b0, 1'b0);
    check_eq("drop_alarm", hb.alarm, 0);
    check_eq("drop_miss", hb.miss_count, 0);
    cyc(1'b1, 1'b0);
    gap(10);
    gap(9);
    check_eq("resync_interval", hb.interval, 10);

    // Late timeout followed one cycle later by a beat: late then early.
    gap(12);
    check_eq("late_miss", hb.miss_count, 1);
    gap(5);
    check_eq("late_early_miss", hb.miss_count, 2);
    check_eq("late_early_int", hb.interval, 2);

    // Asynchronous reset while tracking with cnt at 5.
    @(negedge clk);
    reset      = 1'b1;
    hb.enable  = 1'b0;
    hb.beat_in = 1'b0;
    #1;
    check_all_zero("async_rst");
    m_state = 0; m_miss = 0; m_alarm = 1'b0; m_interval = 0;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    repeat (3) cyc(1'b0, 1'b1);
    cyc(1'b1, 1'b1);
    gap(10);
    gap(10);
    check_eq("post_rst_interval", hb.interval, 10);

    // Random gaps around the window, recovering from any alarm.
    for (int i = 0; i < 25; i++) begin
      gap($urandom_range(7, 14));
      if (m_alarm) begin
        cyc(1'b0, 1'b0);
        cyc(1'b1, 1'b0);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
